// File: rtl/vga_pixel_gen.sv
// VGA pixel generator: two-stage pixel pipeline with black/bars/checker/bouncing-box patterns.
// Optional white frame border on the visible edge when VGA_BORDER_EN is defined.
module vga_pixel_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BOX_SIZE  = 32,
  parameter int unsigned BOX_STEP  = 2,
  parameter int unsigned BOX_X0    = 304,
  parameter int unsigned BOX_Y0    = 224,
  parameter logic [11:0] BOX_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR  = 12'h00F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [1:0]  mode,
  output logic [11:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [10:0] L_HA = 11'(H_ACTIVE);
  localparam logic [10:0] L_VA = 11'(V_ACTIVE);
  localparam logic [10:0] L_BS = 11'(BOX_SIZE);
  localparam logic [10:0] L_ST = 11'(BOX_STEP);
  localparam logic [10:0] L_X0 = 11'(BOX_X0);
  localparam logic [10:0] L_Y0 = 11'(BOX_Y0);

  typedef enum logic [1:0] {DR, DL, UR, UL} box_state_t;

  logic [9:0]  r_x1;
  logic [9:0]  r_y1;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_von1;
  logic        r_vs_prev;
  logic [1:0]  r_mode_q;
  logic [10:0] r_box_x;
  logic [10:0] r_box_y;
  box_state_t  r_state;

  logic        w_frame_tick;
  logic        w_mv_r;
  logic        w_mv_d;
  logic [10:0] w_x_sum;
  logic [10:0] w_y_sum;
  logic        w_x_hit;
  logic        w_y_hit;
  logic [10:0] w_x_nxt;
  logic [10:0] w_y_nxt;
  logic        w_r_nxt;
  logic        w_d_nxt;
  logic [10:0] w_x11;
  logic [10:0] w_y11;
  logic        w_in_box;
  logic [11:0] w_bar;
  logic [11:0] w_rgb;
`ifdef VGA_BORDER_EN
  logic        w_edge;
`endif

  assign w_frame_tick = pix_en & r_vs_prev & ~vsync_in;

  // S1: capture coordinates, syncs and the visible-area flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x1   <= '0;
      r_y1   <= '0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_von1 <= 1'b0;
    end else if (pix_en) begin
      r_x1   <= pixel_x;
      r_y1   <= pixel_y;
      r_hs1  <= hsync_in;
      r_vs1  <= vsync_in;
      r_von1 <= (11'(pixel_x) < L_HA) && (11'(pixel_y) < L_VA);
    end
  end

  // Frame edge detect and per-frame pattern latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vs_prev <= 1'b1;
      r_mode_q  <= 2'b00;
    end else if (pix_en) begin
      r_vs_prev <= vsync_in;
      if (w_frame_tick) r_mode_q <= mode;
    end
  end

  // Next box position per axis, saturating at the visible edges
  always_comb begin
    w_mv_r  = (r_state == DR) || (r_state == UR);
    w_mv_d  = (r_state == DR) || (r_state == DL);
    w_x_sum = r_box_x + L_BS + L_ST;
    w_y_sum = r_box_y + L_BS + L_ST;
    w_x_hit = w_mv_r ? (w_x_sum >= L_HA) : (r_box_x < L_ST);
    w_y_hit = w_mv_d ? (w_y_sum >= L_VA) : (r_box_y < L_ST);
    if (w_mv_r)
      w_x_nxt = w_x_hit ? (L_HA - L_BS) : (r_box_x + L_ST);
    else
      w_x_nxt = w_x_hit ? 11'd0 : (r_box_x - L_ST);
    if (w_mv_d)
      w_y_nxt = w_y_hit ? (L_VA - L_BS) : (r_box_y + L_ST);
    else
      w_y_nxt = w_y_hit ? 11'd0 : (r_box_y - L_ST);
    w_r_nxt = w_mv_r ^ w_x_hit;
    w_d_nxt = w_mv_d ^ w_y_hit;
  end

  // Box FSM: direction state and position, once per frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= DR;
      r_box_x <= L_X0;
      r_box_y <= L_Y0;
    end else if (w_frame_tick) begin
      r_box_x <= w_x_nxt;
      r_box_y <= w_y_nxt;
      unique case ({w_r_nxt, w_d_nxt})
        2'b11: r_state <= DR;
        2'b01: r_state <= DL;
        2'b10: r_state <= UR;
        2'b00: r_state <= UL;
      endcase
    end
  end

  // Colour bar lookup, 64-pixel-wide bars
  always_comb begin
    w_bar = 12'h000;
    unique case (r_x1[8:6])
      3'd0: w_bar = 12'h000;
      3'd1: w_bar = 12'h00F;
      3'd2: w_bar = 12'h0F0;
      3'd3: w_bar = 12'h0FF;
      3'd4: w_bar = 12'hF00;
      3'd5: w_bar = 12'hF0F;
      3'd6: w_bar = 12'hFF0;
      3'd7: w_bar = 12'hFFF;
    endcase
  end

  // Pattern select on the S1 pixel; blanking forces black
  always_comb begin
    w_x11    = {1'b0, r_x1};
    w_y11    = {1'b0, r_y1};
    w_in_box = (w_x11 >= r_box_x) && (w_x11 < r_box_x + L_BS) &&
               (w_y11 >= r_box_y) && (w_y11 < r_box_y + L_BS);
`ifdef VGA_BORDER_EN
    w_edge   = (w_x11 == 11'd0) || (w_x11 == L_HA - 11'd1) ||
               (w_y11 == 11'd0) || (w_y11 == L_VA - 11'd1);
`endif
    w_rgb    = 12'h000;
    if (r_von1) begin
      unique case (r_mode_q)
        2'b00: w_rgb = 12'h000;
        2'b01: w_rgb = w_bar;
        2'b10: w_rgb = (r_x1[5] ^ r_y1[5]) ? 12'hFFF : 12'h000;
        2'b11: w_rgb = w_in_box ? BOX_COLOR : BG_COLOR;
      endcase
`ifdef VGA_BORDER_EN
      if (w_edge) w_rgb = 12'hFFF;
`endif
    end
  end

  // S2: registered colour and syncs realigned to it
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_out   <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else if (pix_en) begin
      rgb_out   <= w_rgb;
      hsync_out <= r_hs1;
      vsync_out <= r_vs1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Testbench for vga_pixel_gen: vector table for patterns plus
// sequences for reset, sync alignment, mode latching and box bounce.
module tb_vga_pixel_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_en = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [1:0]  mode = 2'b00;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;

  int n_checks = 0;
  int n_errors = 0;
  int m_bx, m_by;
  bit m_r, m_d;
  bit border_en;

  typedef struct {
    logic [1:0]  m;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[16];

  vga_pixel_gen dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .mode(mode),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [1:0] m, input int x, input int y,
                      input logic hs, input logic vs);
    @(negedge clk);
    mode = m; pixel_x = 10'(x); pixel_y = 10'(y);
    hsync_in = hs; vsync_in = vs; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic model_reset();
    m_bx = 304; m_by = 224; m_r = 1'b1; m_d = 1'b1;
  endtask

  task automatic model_frame();
    if (m_r) begin
      if (m_bx + 34 >= 640) begin m_bx = 608; m_r = 1'b0; end
      else m_bx = m_bx + 2;
    end else begin
      if (m_bx < 2) begin m_bx = 0; m_r = 1'b1; end
      else m_bx = m_bx - 2;
    end
    if (m_d) begin
      if (m_by + 34 >= 480) begin m_by = 448; m_d = 1'b0; end
      else m_by = m_by + 2;
    end else begin
      if (m_by < 2) begin m_by = 0; m_d = 1'b1; end
      else m_by = m_by - 2;
    end
  endtask

  // one vsync falling edge with a blanked pixel
  task automatic frame(input logic [1:0] m);
    tick(m, 700, 500, 1'b1, 1'b1);
    tick(m, 700, 500, 1'b1, 1'b0);
    model_frame();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pix_en = 1'b1;
    repeat (8) @(negedge clk);
    pix_en = 1'b0;
    model_reset();
  endtask

  function automatic bit is_edge(input int x, input int y);
    return (x < 640) && (y < 480) &&
           (x == 0 || x == 639 || y == 0 || y == 479);
  endfunction

  // pixel probe: apply then flush one tick, return rgb
  task automatic probe(input logic [1:0] m, input int x, input int y,
                       output logic [11:0] rgb);
    tick(m, x, y, 1'b1, 1'b1);
    tick(m, 700, 10, 1'b1, 1'b1);
    rgb = rgb_out;
  endtask

  initial begin
    logic [11:0] got;
    logic [1:0] cur;
    int exp_rgb;
    int low_w;
    logic hs_prev;

`ifdef VGA_BORDER_EN
    border_en = 1'b1;
`else
    border_en = 1'b0;
`endif

    vecs[0]  = '{2'd1, 10'd130, 10'd10,  12'h0F0};
    vecs[1]  = '{2'd1, 10'd700, 10'd10,  12'h000};
    vecs[2]  = '{2'd1, 10'd0,   10'd5,   12'h000};
    vecs[3]  = '{2'd1, 10'd64,  10'd5,   12'h00F};
    vecs[4]  = '{2'd1, 10'd639, 10'd479, 12'h00F};
    vecs[5]  = '{2'd1, 10'd320, 10'd100, 12'hF0F};
    vecs[6]  = '{2'd1, 10'd256, 10'd100, 12'hF00};
    vecs[7]  = '{2'd1, 10'd448, 10'd100, 12'hFFF};
    vecs[8]  = '{2'd1, 10'd200, 10'd480, 12'h000};
    vecs[9]  = '{2'd2, 10'd32,  10'd0,   12'hFFF};
    vecs[10] = '{2'd2, 10'd32,  10'd32,  12'h000};
    vecs[11] = '{2'd2, 10'd100, 10'd40,  12'h000};
    vecs[12] = '{2'd2, 10'd70,  10'd40,  12'hFFF};
    vecs[13] = '{2'd0, 10'd200, 10'd200, 12'h000};
    vecs[14] = '{2'd0, 10'd0,   10'd200, 12'h000};
    vecs[15] = '{2'd0, 10'd1,   10'd200, 12'h000};

    // reset state
    do_reset();
    check("rst_rgb", int'(rgb_out), 0);
    check("rst_hs", int'(hsync_out), 1);
    check("rst_vs", int'(vsync_out), 1);
    check("rst_box_x", int'(dut.r_box_x), 304);
    check("rst_box_y", int'(dut.r_box_y), 224);

    // latency: output follows input after exactly two ticks
    @(negedge clk); rst = 1'b1;
    tick(2'd0, 100, 10, 1'b0, 1'b1);
    check("lat1_hs", int'(hsync_out), 1);
    tick(2'd0, 101, 10, 1'b1, 1'b0);
    check("lat2_hs", int'(hsync_out), 0);
    check("lat2_vs", int'(vsync_out), 1);
    check("lat2_rgb", int'(rgb_out), 0);
    tick(2'd0, 102, 10, 1'b1, 1'b1);
    check("lat3_vs", int'(vsync_out), 0);
    model_frame();

    // pattern vectors
    cur = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].m != cur) begin
        frame(vecs[i].m);
        cur = vecs[i].m;
      end
      probe(cur, int'(vecs[i].x), int'(vecs[i].y), got);
      exp_rgb = (border_en && is_edge(int'(vecs[i].x), int'(vecs[i].y)))
                ? 12'hFFF : int'(vecs[i].exp);
      check($sformatf("vec%0d", i), int'(got), exp_rgb);
    end

    // mode change held off until the next frame
    frame(2'd1);
    probe(2'd2, 130, 10, got);
    check("mode_hold_bars", int'(got), 12'h0F0);
    frame(2'd2);
    probe(2'd2, 32, 0, got);
    check("mode_new_checker", int'(got), 12'hFFF);
    probe(2'd2, 130, 10, got);
    check("mode_new_chk2", int'(got), 12'h000);

    // hsync pulse alignment and width
    low_w = 0;
    hs_prev = 1'b1;
    for (int x = 640; x <= 760; x++) begin
      logic hs;
      hs = !(x >= 656 && x <= 751);
      tick(2'd2, x, 10, hs, 1'b1);
      if (x > 640) begin
        check($sformatf("hs_x%0d", x - 1), int'(hsync_out), int'(hs_prev));
        if (!hsync_out) low_w++;
      end
      hs_prev = hs;
    end
    check("hs_width", low_w, 96);

    // mid-frame reset with hsync low in the pipe
    tick(2'd3, 100, 100, 1'b0, 1'b1);
    tick(2'd3, 101, 100, 1'b0, 1'b1);
    do_reset();
    check("rst2_rgb", int'(rgb_out), 0);
    check("rst2_hs", int'(hsync_out), 1);
    check("rst2_box_x", int'(dut.r_box_x), 304);
    check("rst2_box_y", int'(dut.r_box_y), 224);
    @(negedge clk); rst = 1'b1;
    probe(2'd1, 130, 10, got);
    check("rst2_mode_cleared", int'(got), 0);

    // bounce the box to the right edge
    frame(2'd3);
    for (int f = 0; f < 150; f++) frame(2'd3);
    check("box_151_x", int'(dut.r_box_x), 606);
    check("box_151_xm", int'(dut.r_box_x), m_bx);
    frame(2'd3);
    check("box_sat_x", int'(dut.r_box_x), 608);
    check("box_sat_y", int'(dut.r_box_y), m_by);
    probe(2'd3, 608, m_by, got);
    check("box_in_608", int'(got), 12'hF00);
    probe(2'd3, 607, m_by, got);
    check("box_out_607", int'(got), 12'h00F);
    probe(2'd3, 300, m_by + 31, got);
    check("box_out_row", int'(got), 12'h00F);

    // frame tick on a pixel renders with the pre-update box
    tick(2'd3, 606, m_by, 1'b1, 1'b1);
    tick(2'd3, 700, 500, 1'b1, 1'b0);
    check("box_preupdate", int'(rgb_out), 12'h00F);
    model_frame();
    check("box_left_x", int'(dut.r_box_x), 606);
    check("box_left_y", int'(dut.r_box_y), m_by);
    probe(2'd3, 606, m_by, got);
    check("box_in_606", int'(got), 12'hF00);
    probe(2'd3, 638, m_by, got);
    check("box_out_638", int'(got), 12'h00F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
